// File: rtl/mac_acc_ctrl.sv
// Product accumulator: sums a group of unsigned products and hands the total over a valid/ready port.
// Optional MAC_VAR_LEN_EN adds a len input that sets the group length per group.
module mac_acc_ctrl #(
  parameter int bit_width      = 8,
  parameter int depth          = 4,
  parameter int multiply_width = 2*bit_width,
  parameter int acc_width      = multiply_width+depth-1
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         clear,
  input  logic                         in_valid,
  output logic                         in_ready,
  input  logic [multiply_width-1:0]    in_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [acc_width-1:0]         out_sum,
  output logic [$clog2(depth+1)-1:0]   count,
  output logic                         busy
`ifdef MAC_VAR_LEN_EN
  ,
  input  logic [$clog2(depth+1)-1:0]   len
`endif
);

  localparam int CW = $clog2(depth+1);
  localparam logic [CW-1:0] DEPTH_L = CW'(depth);

  typedef enum logic [1:0] {IDLE, ACC, DONE} state_t;

  state_t               state_q, state_d;
  logic [acc_width-1:0] acc_q, acc_d, sum_add;
  logic [CW-1:0]        cnt_q, cnt_d, cnt_inc;
  logic [CW-1:0]        glen, glen_new;

`ifdef MAC_VAR_LEN_EN
  logic [CW-1:0] glen_q;

  // Out-of-range lengths fall back to a full group.
  function automatic logic [CW-1:0] norm_len(input logic [CW-1:0] l);
    return (l == '0 || l > DEPTH_L) ? DEPTH_L : l;
  endfunction

  assign glen_new = norm_len(len);
  assign glen     = glen_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst)
      glen_q <= DEPTH_L;
    else if (!clear && state_q == IDLE && in_valid)
      glen_q <= glen_new;
  end
`else
  assign glen_new = DEPTH_L;
  assign glen     = DEPTH_L;
`endif

  mac_ripple_add #(
    .a_width (multiply_width),
    .s_width (acc_width)
  ) u_add (
    .a   (in_data),
    .b   (acc_q),
    .sum (sum_add)
  );

  assign cnt_inc = cnt_q + CW'(1);

  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    if (clear) begin
      state_d = IDLE;
      acc_d   = '0;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: if (in_valid) begin
          acc_d   = acc_width'(in_data);
          cnt_d   = CW'(1);
          state_d = (glen_new == CW'(1)) ? DONE : ACC;
        end
        ACC: if (in_valid) begin
          acc_d = sum_add;
          cnt_d = cnt_inc;
          if (cnt_inc == glen) state_d = DONE;
        end
        // The result handoff cycle never accepts a new product.
        DONE: if (out_ready) begin
          state_d = IDLE;
          acc_d   = '0;
          cnt_d   = '0;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      acc_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign in_ready  = (state_q != DONE);
  assign out_valid = (state_q == DONE);
  assign busy      = (state_q != IDLE);
  assign out_sum   = acc_q;
  assign count     = cnt_q;

endmodule

// Ripple-carry adder: full adders over the width of a, half adders carrying into the upper bits of b.
module mac_ripple_add #(
  parameter int a_width = 16,
  parameter int s_width = 19
) (
  input  logic [a_width-1:0] a,
  input  logic [s_width-1:0] b,
  output logic [s_width-1:0] sum
);

  logic [s_width-1:0] c;

  assign c[0] = 1'b0;

  for (genvar i = 0; i < s_width; i++) begin : g_bit
    logic p;
    if (i < a_width) begin : g_fp
      assign p = a[i] ^ b[i];
    end else begin : g_hp
      assign p = b[i];
    end
    assign sum[i] = p ^ c[i];
    if (i < s_width-1) begin : g_carry
      if (i < a_width) begin : g_fa
        assign c[i+1] = (a[i] & b[i]) | (p & c[i]);
      end else begin : g_ha
        assign c[i+1] = b[i] & c[i];
      end
    end
  end

endmodule
